// File: rtl/ube_dma_seq.sv
// ube_dma_seq: Unibus Exerciser DMA sequencer; runs NPR transfer cycles and pulses ubeINC until regCC wraps to zero.
// Optional XFER ack timeout with sticky NXM abort is built when UBE_NXM_TIMEOUT_EN is defined.
module ube_dma_seq #(
    parameter int TIMEOUT = 127
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        devRESET,
    input  logic        ubeGO,
    input  logic [15:0] regCC,
    input  logic        dmaGNT,
    input  logic        busACK,
    output logic        dmaREQ,
    output logic        busCYC,
    output logic        ubeINC,
    output logic        ubeBUSY,
    output logic        ubeDONE,
    output logic        ubeNXM
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_XFER,
        S_INC,
        S_CHK
    } state_t;

    localparam logic [6:0] TMO_LAST = 7'(TIMEOUT - 1);

    state_t state_q;
    logic   req_q;
    logic   cyc_q;
    logic   inc_q;
    logic   busy_q;
    logic   done_q;

    // Bit 0 of the count never takes part in termination, so odd counts still end.
    logic   unused_cc;
    assign unused_cc = regCC[0];

`ifdef UBE_NXM_TIMEOUT_EN
    logic [6:0] tmo_q;
    logic       nxm_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            req_q   <= 1'b0;
            cyc_q   <= 1'b0;
            inc_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            nxm_q   <= 1'b0;
            tmo_q   <= '0;
        end else if (devRESET) begin
            state_q <= S_IDLE;
            req_q   <= 1'b0;
            cyc_q   <= 1'b0;
            inc_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            nxm_q   <= 1'b0;
            tmo_q   <= '0;
        end else begin
            inc_q <= 1'b0;
            case (state_q)
                S_IDLE: if (ubeGO) begin
                    state_q <= S_REQ;
                    req_q   <= 1'b1;
                    busy_q  <= 1'b1;
                    done_q  <= 1'b0;
                    nxm_q   <= 1'b0;
                end
                S_REQ: if (dmaGNT) begin
                    state_q <= S_XFER;
                    cyc_q   <= 1'b1;
                end
                S_XFER: begin
                    // An ack arriving on the last allowed cycle still completes the transfer.
                    if (busACK) begin
                        state_q <= S_INC;
                        req_q   <= 1'b0;
                        cyc_q   <= 1'b0;
                        inc_q   <= 1'b1;
                        tmo_q   <= '0;
                    end else if (tmo_q == TMO_LAST) begin
                        state_q <= S_IDLE;
                        req_q   <= 1'b0;
                        cyc_q   <= 1'b0;
                        busy_q  <= 1'b0;
                        nxm_q   <= 1'b1;
                        tmo_q   <= '0;
                    end else begin
                        tmo_q <= tmo_q + 7'd1;
                    end
                end
                S_INC: state_q <= S_CHK;
                S_CHK: if (regCC[15:1] == '0) begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                end else begin
                    state_q <= S_REQ;
                    req_q   <= 1'b1;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign ubeNXM = nxm_q;
`else
    logic unused_tmo;
    assign unused_tmo = ^TMO_LAST;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            req_q   <= 1'b0;
            cyc_q   <= 1'b0;
            inc_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else if (devRESET) begin
            state_q <= S_IDLE;
            req_q   <= 1'b0;
            cyc_q   <= 1'b0;
            inc_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            inc_q <= 1'b0;
            case (state_q)
                S_IDLE: if (ubeGO) begin
                    state_q <= S_REQ;
                    req_q   <= 1'b1;
                    busy_q  <= 1'b1;
                    done_q  <= 1'b0;
                end
                S_REQ: if (dmaGNT) begin
                    state_q <= S_XFER;
                    cyc_q   <= 1'b1;
                end
                S_XFER: if (busACK) begin
                    state_q <= S_INC;
                    req_q   <= 1'b0;
                    cyc_q   <= 1'b0;
                    inc_q   <= 1'b1;
                end
                S_INC: state_q <= S_CHK;
                S_CHK: if (regCC[15:1] == '0) begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                end else begin
                    state_q <= S_REQ;
                    req_q   <= 1'b1;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign ubeNXM = 1'b0;
`endif

    assign dmaREQ  = req_q;
    assign busCYC  = cyc_q;
    assign ubeINC  = inc_q;
    assign ubeBUSY = busy_q;
    assign ubeDONE = done_q;

endmodule

// File: tb/tb_ube_dma_seq.sv
// tb_ube_dma_seq: table vectors, corner sequences and randomized runs against a transfer-level model.
// Bench follows UBE_NXM_TIMEOUT_EN the same way the design does.
module tb_ube_dma_seq;

    localparam int TMO = 127;
`ifdef UBE_NXM_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        devRESET;
    logic        ubeGO;
    logic [15:0] regCC = '0;
    logic        dmaGNT = 1'b0;
    logic        busACK = 1'b0;
    logic        dmaREQ, busCYC, ubeINC, ubeBUSY, ubeDONE, ubeNXM;

    ube_dma_seq #(.TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .devRESET(devRESET), .ubeGO(ubeGO), .regCC(regCC),
        .dmaGNT(dmaGNT), .busACK(busACK), .dmaREQ(dmaREQ), .busCYC(busCYC),
        .ubeINC(ubeINC), .ubeBUSY(ubeBUSY), .ubeDONE(ubeDONE), .ubeNXM(ubeNXM)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Per-transfer grant and ack delays, indexed by transfers since the run began.
    int gd_tab[64];
    int ad_tab[64];
    int base = 0;
    int inc_cnt = 0;
    logic        hw = 1'b0;
    logic [15:0] hv = '0;

    // Arbiter, slave and register-file model, acting on the falling edge.
    int rcnt = 0;
    int xcnt = 0;
    int idx;
    always @(negedge clk) begin
        idx = inc_cnt - base;
        if (idx < 0 || idx > 63) idx = 63;
        if (dmaREQ && !busCYC) begin
            dmaGNT = (rcnt >= gd_tab[idx]);
            rcnt++;
        end else begin
            dmaGNT = 1'b0;
            rcnt = 0;
        end
        if (busCYC) begin
            busACK = (xcnt == ad_tab[idx]);
            xcnt++;
        end else begin
            busACK = 1'b0;
            xcnt = 0;
        end
        if (hw) regCC = hv;
        else if (ubeINC) begin
            regCC = regCC + 16'd2;
            inc_cnt++;
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input int gd, input int ad);
        for (int i = 0; i < 64; i++) begin
            gd_tab[i] = gd;
            ad_tab[i] = ad;
        end
    endtask

    // Transfer-level expectation: each transfer costs grant wait + ack wait + INC + CHK.
    function automatic void model(input logic [15:0] cc0, output int n, output int cyc,
                                  output logic [15:0] ccf, output logic done, output logic nxm);
        logic [15:0] cc;
        cc = cc0; n = 0; cyc = 0; done = 1'b0; nxm = 1'b0;
        for (int i = 0; i < 64; i++) begin
            cyc += gd_tab[i] + 1;
            if (TMO_EN && ad_tab[i] >= TMO) begin
                cyc += TMO;
                nxm = 1'b1;
                break;
            end
            cyc += ad_tab[i] + 3;
            cc = cc + 16'd2;
            n++;
            if (cc < 16'd2) begin
                done = 1'b1;
                break;
            end
        end
        ccf = cc;
    endfunction

    task automatic start(input logic [15:0] cc0);
        tick();
        hv = cc0; hw = 1'b1;
        tick();
        hw = 1'b0; ubeGO = 1'b1; base = inc_cnt;
        tick();
        ubeGO = 1'b0;
        chk("go.busy", ubeBUSY, 1);
        chk("go.done", ubeDONE, 0);
        chk("go.nxm", ubeNXM, 0);
    endtask

    task automatic wait_idle(output int cyc);
        cyc = 0;
        while (ubeBUSY && cyc < 5000) begin
            tick();
            cyc++;
        end
        if (cyc >= 5000) chk("idle.timeout", cyc, -1);
    endtask

    task automatic wait_incs(input int n);
        int k;
        k = 0;
        while ((inc_cnt - base) < n && k < 5000) begin
            tick();
            k++;
        end
        if (k >= 5000) chk("incs.timeout", inc_cnt - base, n);
    endtask

    task automatic run(input string nm, input logic [15:0] cc0);
        int en, ecyc, cyc;
        logic [15:0] ecc;
        logic ed, enx;
        model(cc0, en, ecyc, ecc, ed, enx);
        start(cc0);
        wait_idle(cyc);
        chk({nm, ".incs"}, inc_cnt - base, en);
        chk({nm, ".cyc"}, cyc, ecyc);
        chk({nm, ".cc"}, regCC, ecc);
        chk({nm, ".done"}, ubeDONE, ed);
        chk({nm, ".nxm"}, ubeNXM, enx);
    endtask

    typedef struct {
        logic [15:0] cc;
        int          gd;
        int          ad;
        int          incs;
        int          cyc;
        logic [15:0] fcc;
    } vec_t;

    vec_t tbl[5];

    initial begin
        int c;
        logic [15:0] cc0;
        fill(0, 0);
        tbl[0] = '{16'o177770, 0, 0, 4, 16, 16'h0000};
        tbl[1] = '{16'o177776, 10, 0, 1, 14, 16'h0000};
        tbl[2] = '{16'o177777, 0, 0, 1, 4, 16'h0001};
        tbl[3] = '{16'hFFFA, 2, 3, 3, 27, 16'h0000};
        tbl[4] = '{16'hFFFB, 1, 0, 3, 15, 16'h0001};

        rst = 1'b1; devRESET = 1'b0; ubeGO = 1'b0;
        tick();
        chk("rst.req", dmaREQ, 0);
        chk("rst.cyc", busCYC, 0);
        chk("rst.inc", ubeINC, 0);
        chk("rst.busy", ubeBUSY, 0);
        chk("rst.done", ubeDONE, 0);
        chk("rst.nxm", ubeNXM, 0);
        tick();
        rst = 1'b0;

        for (int v = 0; v < 5; v++) begin
            fill(tbl[v].gd, tbl[v].ad);
            start(tbl[v].cc);
            wait_idle(c);
            chk($sformatf("tbl%0d.incs", v), inc_cnt - base, tbl[v].incs);
            chk($sformatf("tbl%0d.cyc", v), c, tbl[v].cyc);
            chk($sformatf("tbl%0d.cc", v), regCC, tbl[v].fcc);
            chk($sformatf("tbl%0d.done", v), ubeDONE, 1);
            chk($sformatf("tbl%0d.nxm", v), ubeNXM, 0);
        end

        // GO during a run is ignored; GO after DONE clears it as BUSY rises.
        fill(0, 0);
        chk("go2.done_before", ubeDONE, 1);
        start(16'o177770);
        repeat (5) tick();
        ubeGO = 1'b1;
        tick();
        ubeGO = 1'b0;
        wait_idle(c);
        chk("gobusy.cyc", c + 6, 16);
        chk("gobusy.incs", inc_cnt - base, 4);
        chk("gobusy.done", ubeDONE, 1);

        // devRESET in idle clears DONE.
        devRESET = 1'b1;
        tick();
        devRESET = 1'b0;
        chk("devrst.idle.done", ubeDONE, 0);

        // devRESET after the third increment.
        start(16'o177000);
        wait_incs(3);
        devRESET = 1'b1;
        tick();
        devRESET = 1'b0;
        chk("devrst.busy", ubeBUSY, 0);
        chk("devrst.req", dmaREQ, 0);
        chk("devrst.cyc", busCYC, 0);
        chk("devrst.done", ubeDONE, 0);
        repeat (12) tick();
        chk("devrst.incs", inc_cnt - base, 3);
        chk("devrst.req2", dmaREQ, 0);

        // Start from zero does not terminate early; a host rewrite is honoured at the next check.
        start(16'h0000);
        wait_incs(5);
        chk("wrap.busy", ubeBUSY, 1);
        chk("wrap.done", ubeDONE, 0);
        hv = 16'hFFFC; hw = 1'b1;
        tick();
        hw = 1'b0;
        wait_idle(c);
        chk("rewrite.incs", inc_cnt - base, 7);
        chk("rewrite.cc", regCC, 0);
        chk("rewrite.done", ubeDONE, 1);

        // Async reset mid-run drops outputs before the next clock edge.
        start(16'o177770);
        repeat (3) tick();
        rst = 1'b1;
        #1;
        chk("arst.busy", ubeBUSY, 0);
        chk("arst.req", dmaREQ, 0);
        tick();
        rst = 1'b0;

        // Slow ack: ack on the last allowed cycle wins, beyond that the run aborts (timeout builds only).
        fill(0, 126);
        run("ack126", 16'hFFFE);
        fill(0, 200);
        run("ack200", 16'hFFFE);
        fill(3, 150);
        run("ack150", 16'hFFFC);

        for (int r = 0; r < 20; r++) begin
            cc0 = 16'hFFFF - 16'($urandom_range(0, 40));
            for (int i = 0; i < 64; i++) begin
                gd_tab[i] = int'($urandom_range(0, 4));
                ad_tab[i] = int'($urandom_range(0, 4));
                if ($urandom_range(0, 15) == 0) ad_tab[i] = int'($urandom_range(125, 128));
            end
            run($sformatf("rnd%0d", r), cc0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
